// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver with a small first-word-fall-through byte FIFO
// and a valid/ready output handshake. Flags framing errors and overruns as
// one-cycle pulses.
`timescale 1ns/1ps
module uart_rx_fifo #(
  parameter int CLK_FREQUENCY = 100_000_000,
  parameter int BAUD          = 115_200,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       rx_busy
);

  localparam int CLKS_PER_BIT = CLK_FREQUENCY / BAUD;
  localparam int HALF         = CLKS_PER_BIT / 2;
  localparam int CW           = $clog2(CLKS_PER_BIT);
  localparam int PW           = $clog2(FIFO_DEPTH);

  localparam logic [CW-1:0] HALF_M1  = CW'(HALF - 1);
  localparam logic [CW-1:0] BIT_M1   = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [PW:0]   CNT1     = (PW+1)'(1);
  localparam logic [PW:0]   FULL_CNT = (PW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_e;

  logic                      rxd_meta_q, rxd_s_q;
  state_e                    state_q, state_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [2:0]                bit_q, bit_d;
  logic [7:0]                shreg_q, shreg_d;
  logic                      frame_err_q, frame_err_d;
  logic                      overrun_q, overrun_d;
  logic [FIFO_DEPTH-1:0][7:0] mem_q, mem_d;
  logic [PW-1:0]             wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]               count_q, count_d;
  logic                      push, pop, full, push_ok;

  // Two-flop synchroniser on the asynchronous line, parked at idle level in reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rxd_meta_q <= 1'b1;
      rxd_s_q    <= 1'b1;
    end else begin
      rxd_meta_q <= rxd;
      rxd_s_q    <= rxd_meta_q;
    end
  end

  // Receive FSM: start qualification at mid start bit, then one sample per bit
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    shreg_d     = shreg_q;
    push        = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rxd_s_q) state_d = S_START;
      end
      S_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rxd_s_q ? S_IDLE : S_DATA;  // high again: a glitch, not a start
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_DATA: begin
        if (cnt_q == BIT_M1) begin
          cnt_d   = '0;
          shreg_d = {rxd_s_q, shreg_q[7:1]};    // LSB arrives first
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_STOP: begin
        if (cnt_q == BIT_M1) begin
          cnt_d = '0;
          if (rxd_s_q) begin
            push    = 1'b1;
            state_d = S_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_BREAK;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_BREAK: begin
        // a line held low must not be re-read as a stream of frames
        if (rxd_s_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FIFO bookkeeping: a push into a full FIFO only lands if the head leaves this cycle
  always_comb begin
    pop       = rx_valid & rx_ready;
    full      = (count_q == FULL_CNT);
    push_ok   = push & (~full | pop);
    overrun_d = push & full & ~pop;
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = shreg_q;
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + CNT1;
      2'b01:   count_d = count_q - CNT1;
      default: count_d = count_q;
    endcase
  end

  // State registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      shreg_q     <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      mem_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shreg_q     <= shreg_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  assign rx_data   = mem_q[rd_ptr_q];
  assign rx_valid  = (count_q != '0);
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign rx_busy   = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: a queue model of received bytes, fed by the frames the
// bench sends and their ideal completion cycle, checked against the DUT every cycle.
`timescale 1ns/1ps
module tb_uart_rx_fifo;
  localparam int CPB   = 64;
  localparam int HALF  = CPB / 2;
  localparam int DEPTH = 4;
  localparam int LAT   = 3 + HALF + 9 * CPB;  // edges from start drive to visible result

  logic       clk = 1'b0, reset_n = 1'b0, rxd = 1'b1, rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, overrun, rx_busy;

  uart_rx_fifo #(.CLK_FREQUENCY(6_400_000), .BAUD(100_000), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .rxd(rxd), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .frame_err(frame_err), .overrun(overrun), .rx_busy(rx_busy));

  always #5 clk = ~clk;

  typedef struct { int at; logic [7:0] b; bit ok; } ev_t;
  ev_t        ev[$];
  logic [7:0] mq[$];
  logic [7:0] acc[$];
  int total = 0, bad = 0, cyc = 0;
  bit e_ferr = 0, e_ovr = 0;
  int ferr_cnt = 0, ovr_cnt = 0, vcnt = 0, busy_cnt = 0, rise_cyc = -1, s0 = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Model update at each active edge: pop, then completed frames push or flag
  always @(posedge clk) begin
    cyc++;
    e_ferr = 1'b0;
    e_ovr  = 1'b0;
    if (!reset_n) begin
      mq.delete();
      ev.delete();
    end else begin
      if (mq.size() != 0 && rx_ready) void'(mq.pop_front());
      while (ev.size() != 0 && ev[0].at == cyc) begin
        if (!ev[0].ok) e_ferr = 1'b1;
        else if (mq.size() < DEPTH) mq.push_back(ev[0].b);
        else e_ovr = 1'b1;
        void'(ev.pop_front());
      end
    end
  end

  // Compare on the falling edge, away from the active edge
  always @(negedge clk) begin
    if (!reset_n) begin
      mq.delete();
      chk("rst_valid", rx_valid, 0);
      chk("rst_data", rx_data, 0);
      chk("rst_ferr", frame_err, 0);
      chk("rst_ovr", overrun, 0);
      chk("rst_busy", rx_busy, 0);
    end else begin
      chk("valid", rx_valid, mq.size() != 0);
      if (mq.size() != 0) chk("data", rx_data, mq[0]);
      chk("frame_err", frame_err, e_ferr);
      chk("overrun", overrun, e_ovr);
      if (frame_err) ferr_cnt++;
      if (overrun) ovr_cnt++;
      if (rx_valid) vcnt++;
      if (rx_busy) busy_cnt++;
      if (rx_valid && rise_cyc < 0) rise_cyc = cyc;
      if (rx_valid && rx_ready) acc.push_back(rx_data);
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // One 8N1 frame; with a low stop bit the line is left low for the caller
  task automatic send(input logic [7:0] b, input bit stop_hi, input bit sched);
    rxd = 1'b0;
    if (sched) ev.push_back('{cyc + LAT, b, stop_hi});
    step(CPB);
    for (int i = 0; i < 8; i++) begin rxd = b[i]; step(CPB); end
    rxd = stop_hi;
    step(CPB);
  endtask

  task automatic chk_acc(input string nm, input logic [7:0] e0, input logic [7:0] e1,
                         input logic [7:0] e2, input logic [7:0] e3, input int n);
    logic [7:0] e [4];
    e = '{e0, e1, e2, e3};
    chk({nm, "_count"}, acc.size(), n);
    for (int i = 0; i < n && i < acc.size(); i++) chk({nm, "_byte"}, acc[i], e[i]);
  endtask

  initial begin
    step(3);
    chk("reset_valid", rx_valid, 0);
    chk("reset_data", rx_data, 0);
    chk("reset_busy", rx_busy, 0);
    reset_n = 1'b1;
    step(5);

    // single byte, consumer always ready
    rx_ready = 1'b1; acc.delete(); vcnt = 0; rise_cyc = -1; s0 = cyc;
    send(8'hA5, 1'b1, 1'b1);
    step(CPB);
    chk("t1_latency", rise_cyc - s0, 611);
    chk("t1_valid_cycles", vcnt, 1);
    chk_acc("t1", 8'hA5, 8'h00, 8'h00, 8'h00, 1);
    chk("t1_errs", ferr_cnt + ovr_cnt, 0);

    // four back-to-back bytes buffered, then drained in order
    rx_ready = 1'b0; acc.delete();
    send(8'h01, 1'b1, 1'b1); send(8'h80, 1'b1, 1'b1);
    send(8'hFF, 1'b1, 1'b1); send(8'h00, 1'b1, 1'b1);
    step(4);
    chk("t2_head_valid", rx_valid, 1);
    chk("t2_head_data", rx_data, 8'h01);
    rx_ready = 1'b1; step(8); rx_ready = 1'b0;
    chk_acc("t2", 8'h01, 8'h80, 8'hFF, 8'h00, 4);
    chk("t2_empty", rx_valid, 0);

    // fifth byte into a full FIFO is dropped
    ovr_cnt = 0; acc.delete();
    for (int i = 0; i < 5; i++) send(8'h10 + 8'(i), 1'b1, 1'b1);
    step(4);
    chk("t3_overrun_pulses", ovr_cnt, 1);
    rx_ready = 1'b1; step(8); rx_ready = 1'b0;
    chk_acc("t3", 8'h10, 8'h11, 8'h12, 8'h13, 4);

    // low stop bit, line held low, then a clean frame
    ferr_cnt = 0; acc.delete(); rx_ready = 1'b1;
    send(8'h55, 1'b0, 1'b1);
    step(3 * CPB);
    chk("t4_break_busy", rx_busy, 1);
    chk("t4_ferr_pulses", ferr_cnt, 1);
    chk("t4_nothing_pushed", acc.size(), 0);
    rxd = 1'b1; step(CPB);
    chk("t4_idle_after_break", rx_busy, 0);
    send(8'h3C, 1'b1, 1'b1);
    step(CPB);
    chk_acc("t4", 8'h3C, 8'h00, 8'h00, 8'h00, 1);
    chk("t4_ferr_total", ferr_cnt, 1);

    // short low glitch on an idle line
    busy_cnt = 0; acc.delete(); ferr_cnt = 0; ovr_cnt = 0;
    rxd = 1'b0; step(20); rxd = 1'b1; step(CPB);
    chk("t5_busy_seen", busy_cnt != 0, 1);
    chk("t5_busy_bounded", busy_cnt <= HALF + 2, 1);
    chk("t5_no_push", acc.size(), 0);
    chk("t5_no_err", ferr_cnt + ovr_cnt, 0);

    // reset in the middle of a frame with two bytes buffered
    rx_ready = 1'b0; acc.delete();
    send(8'h20, 1'b1, 1'b1); send(8'h21, 1'b1, 1'b1);
    step(4);
    chk("t6_prefill", rx_valid, 1);
    rxd = 1'b0; step(CPB);
    rxd = 1'b1; step(CPB);
    rxd = 1'b1; step(CPB / 2);
    chk("t6_busy_mid", rx_busy, 1);
    reset_n = 1'b0; #1;
    chk("t6_valid_now", rx_valid, 0);
    chk("t6_busy_now", rx_busy, 0);
    step(3);
    reset_n = 1'b1; ferr_cnt = 0; ovr_cnt = 0;
    step(5);
    send(8'hC3, 1'b1, 1'b1);
    step(CPB);
    rx_ready = 1'b1; step(4); rx_ready = 1'b0;
    chk_acc("t6", 8'hC3, 8'h00, 8'h00, 8'h00, 1);
    chk("t6_no_err", ferr_cnt + ovr_cnt, 0);

    step(4);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
